// File: rtl/obc_da_seq_ctrl.sv
`default_nettype none
// ============================================================================
// obc_da_seq_ctrl : bit-serial sequencer + shift-accumulator, OBC DA 16-pt DFT
// Revision: 1.0
// ============================================================================
module obc_da_seq_ctrl #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int RES_W  = 48
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [16*DATA_W-1:0]          in_data,
   output logic [15:0]                   bit_slice,
   output logic [$clog2(DATA_W)-1:0]     bit_idx,
   output logic                          msb_cycle,
   input  logic signed [ACC_W-1:0]       rom_sum,
   input  logic signed [ACC_W-1:0]       offset_val,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [RES_W-1:0]       out_data,
   output logic                          busy
);

   localparam int N_SMP = 16;
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_OFFSET = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                   r_state, w_next;
   logic [CNT_W-1:0]         r_cnt;
   logic signed [RES_W-1:0]  r_acc;
   logic [DATA_W-1:0]        r_sreg [N_SMP];

   logic signed [RES_W-1:0]  w_rom_ext;
   logic signed [RES_W-1:0]  w_off_ext;
   logic                     w_first;

   assign w_rom_ext = {{(RES_W-ACC_W){rom_sum[ACC_W-1]}}, rom_sum};
   assign w_off_ext = {{(RES_W-ACC_W){offset_val[ACC_W-1]}}, offset_val};
   assign w_first   = (r_cnt == CNT_W'(DATA_W-1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      bit_slice = '0;
      bit_idx   = '0;
      msb_cycle = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            busy      = 1'b1;
            bit_idx   = r_cnt;
            msb_cycle = w_first;
            for (int k = 0; k < N_SMP; k++) bit_slice[k] = r_sreg[k][DATA_W-1];
            if (r_cnt == '0) w_next = S_OFFSET;
         end
         S_OFFSET: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = r_acc;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Sign bit carries negative weight, so the MSB slice seeds the accumulator negated.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_acc <= '0;
         for (int k = 0; k < N_SMP; k++) r_sreg[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_cnt <= CNT_W'(DATA_W-1);
                  r_acc <= '0;
                  for (int k = 0; k < N_SMP; k++)
                     r_sreg[k] <= in_data[k*DATA_W +: DATA_W];
               end
            end
            S_RUN: begin
               if (w_first) r_acc <= -w_rom_ext;
               else         r_acc <= (r_acc <<< 1) + w_rom_ext;
               r_cnt <= r_cnt - CNT_W'(1);
               for (int k = 0; k < N_SMP; k++)
                  r_sreg[k] <= {r_sreg[k][DATA_W-2:0], 1'b0};
            end
            S_OFFSET: r_acc <= r_acc + w_off_ext;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_obc_da_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_obc_da_seq_ctrl : directed self-checking bench for obc_da_seq_ctrl
// Revision: 1.0
// ============================================================================
module tb_obc_da_seq_ctrl;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int RW = 48;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [16*DW-1:0]      in_data;
   logic [15:0]           bit_slice;
   logic [3:0]            bit_idx;
   logic                  msb_cycle;
   logic signed [AW-1:0]  rom_sum;
   logic signed [AW-1:0]  offset_val;
   logic                  out_valid;
   logic                  out_ready;
   logic [RW-1:0]         out_data;
   logic                  busy;

   int total = 0;
   int bad   = 0;
   int rom_mode = 0;

   always #5 clk = ~clk;

   obc_da_seq_ctrl #(.DATA_W(DW), .ACC_W(AW), .RES_W(RW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bit_slice(bit_slice), .bit_idx(bit_idx), .msb_cycle(msb_cycle),
      .rom_sum(rom_sum), .offset_val(offset_val),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   // ROM model: coefficient of sample k is k+1, or a constant 1 in mode 1.
   always_comb begin
      rom_sum = '0;
      if (rom_mode == 1) rom_sum = 1;
      else
         for (int k = 0; k < 16; k++)
            if (bit_slice[k]) rom_sum = rom_sum + AW'(k + 1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic accept(input logic [16*DW-1:0] d, input logic signed [AW-1:0] off);
      int n = 0;
      in_data = d;
      offset_val = off;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin step(); n++; end
      chk("accept_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic wait_out(input string tag, input logic [RW-1:0] exp, input bit drop_valid);
      int n = 1;
      step();
      if (drop_valid) in_valid = 1'b0;
      while (!out_valid && n < 40) begin step(); n++; end
      chk({tag, "_lat"}, 64'(n), 64'd18);
      chk({tag, "_data"}, 64'(out_data), 64'(exp));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hs_in_ready", 64'(in_ready), 64'd1);
   endtask

   logic [16*DW-1:0] d;
   int msb_cnt;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; offset_val = '0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_bit_slice", 64'(bit_slice), 64'd0);
      chk("rst_bit_idx", 64'(bit_idx), 64'd0);
      chk("rst_msb", 64'(msb_cycle), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // t1: sample0 = -32765, offset 5
      rom_mode = 0;
      d = '0; d[15:0] = 16'h8003;
      accept(d, 5);
      wait_out("t1", 48'hFFFF_FFFF_8008, 1'b1);
      handshake();

      // t2: constant rom_sum, single msb cycle
      rom_mode = 1;
      d = '0; d[3*DW +: DW] = 16'h1234;
      accept(d, 0);
      msb_cnt = 0;
      for (int c = 1; c <= 18; c++) begin
         step();
         if (c == 1) in_valid = 1'b0;
         if (c == 5) chk("t2_busy", 64'(busy), 64'd1);
         if (msb_cycle) begin
            msb_cnt++;
            chk("t2_msb_idx", 64'(bit_idx), 64'd15);
            chk("t2_msb_cyc", 64'(c), 64'd1);
         end
      end
      chk("t2_msb_cnt", 64'(msb_cnt), 64'd1);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_data", 64'(out_data), 64'hFFFF_FFFF_FFFF);
      handshake();

      // t3: sample9 = 1, bit_slice only on the bit 0 cycle
      rom_mode = 0;
      d = '0; d[9*DW +: DW] = 16'h0001;
      accept(d, 0);
      for (int c = 1; c <= 18; c++) begin
         step();
         if (c == 1) in_valid = 1'b0;
         chk("t3_bit_slice", 64'(bit_slice), (c == 16) ? 64'h0200 : 64'h0);
         chk("t3_valid", 64'(out_valid), (c == 18) ? 64'd1 : 64'd0);
      end
      chk("t3_data", 64'(out_data), 64'd10);
      handshake();

      // t4: hold in DONE with out_ready low; in_valid pulse ignored
      d = '0; d[2*DW +: DW] = 16'hFFFD; d[15*DW +: DW] = 16'd100;
      accept(d, -7);
      wait_out("t4", 48'd1584, 1'b1);
      d = '0; d[0 +: DW] = 16'h0055;
      in_data = d;
      for (int c = 1; c <= 5; c++) begin
         in_valid = (c == 2);
         step();
         chk("t4_hold_valid", 64'(out_valid), 64'd1);
         chk("t4_hold_data", 64'(out_data), 64'd1584);
         chk("t4_hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      handshake();
      chk("t4_idle_busy", 64'(busy), 64'd0);
      chk("t4_idle_valid", 64'(out_valid), 64'd0);
      step(); step();
      chk("t4_no_capture", 64'(busy), 64'd0);

      // t5: reset in the 8th RUN cycle, then a clean block
      d = '0; d[0 +: DW] = 16'h7FFF; d[4*DW +: DW] = 16'h9ABC;
      accept(d, 3);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) in_valid = 1'b0;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_bit_slice", 64'(bit_slice), 64'd0);
      d = '0; d[5*DW +: DW] = 16'h7FFF;
      accept(d, 0);
      wait_out("t5", 48'd196602, 1'b1);
      handshake();

      // t6: back-to-back blocks with in_valid held high
      d = '0;
      for (int k = 0; k < 16; k++) d[k*DW +: DW] = 16'h0001;
      accept(d, 1);
      step();
      in_data = '1;
      begin
         int n = 1;
         while (!out_valid && n < 40) begin step(); n++; end
         chk("t6a_lat", 64'(n), 64'd18);
      end
      chk("t6a_data", 64'(out_data), 64'd137);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t6b_accept_ready", 64'(in_ready), 64'd1);
      wait_out("t6b", -48'sd135, 1'b1);
      handshake();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
